// File: rtl/collect_window_counter.sv
// rtl/collect_window_counter.sv - per-frame event counter gated by collect_enable, valid/ack readout
// Optional event dead time: define COLLECT_DEADTIME_EN.
module collect_window_counter #(
   parameter int CNT_W       = 16,
   parameter int WIN_W       = 24,
   parameter int MAX_WIN     = 5000000,
   parameter int DEAD_CYCLES = 8
) (
   input  logic             clk50,
   input  logic             rst_n,
   input  logic             frame_start,
   input  logic             collect_enable,
   input  logic             event_in,
   input  logic             rd_ack,
   output logic [CNT_W-1:0] count_data,
   output logic [7:0]       frame_id,
   output logic             overflow,
   output logic             data_valid,
   output logic [1:0]       state_o
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARMED   = 2'd1,
      COLLECT = 2'd2,
      HOLD    = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] acc_q, acc_d;
   logic [WIN_W-1:0] win_q, win_d;
   logic             ovf_int_q, ovf_int_d;
   logic             pend_q, pend_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [7:0]       fid_q, fid_d;
   logic             ovf_q, ovf_d;
   logic             dv_q, dv_d;
   logic             ev_meta_q, ev_sync_q, ev_prev_q;
   logic             event_pulse;
   logic             count_en;
   logic             close_win;

   assign event_pulse = ev_sync_q & ~ev_prev_q;

`ifdef COLLECT_DEADTIME_EN
   localparam int DW = $clog2(DEAD_CYCLES + 1);
   logic [DW-1:0] dead_q, dead_d;
   assign count_en = event_pulse && (dead_q == '0);
`else
   assign count_en = event_pulse;
`endif

   assign close_win = !collect_enable || (win_q == WIN_W'(MAX_WIN - 1)) || frame_start;

   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      win_d     = win_q;
      ovf_int_d = ovf_int_q;
      pend_d    = pend_q;
      count_d   = count_q;
      fid_d     = fid_q;
      ovf_d     = ovf_q;
      dv_d      = dv_q;
`ifdef COLLECT_DEADTIME_EN
      dead_d    = dead_q;
`endif
      case (state_q)
         IDLE: begin
            if (frame_start) state_d = ARMED;
         end
         ARMED: begin
            if (collect_enable) begin
               state_d   = COLLECT;
               acc_d     = '0;
               win_d     = '0;
               ovf_int_d = 1'b0;
`ifdef COLLECT_DEADTIME_EN
               dead_d    = '0;
`endif
            end
         end
         COLLECT: begin
            win_d = win_q + WIN_W'(1);
            if (count_en) begin
               if (acc_q == {CNT_W{1'b1}}) ovf_int_d = 1'b1;
               else                        acc_d = acc_q + CNT_W'(1);
            end
`ifdef COLLECT_DEADTIME_EN
            if (count_en)            dead_d = DW'(DEAD_CYCLES);
            else if (dead_q != '0)   dead_d = dead_q - DW'(1);
`endif
            // The close cycle still counts its pulse, so latch the updated values.
            if (close_win) begin
               count_d = acc_d;
               ovf_d   = ovf_int_d;
               fid_d   = fid_q + 8'd1;
               dv_d    = 1'b1;
               pend_d  = frame_start;
               state_d = HOLD;
            end
         end
         HOLD: begin
            if (frame_start) pend_d = 1'b1;
            if (rd_ack) begin
               dv_d    = 1'b0;
               pend_d  = 1'b0;
               state_d = (pend_q || frame_start) ? ARMED : IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk50 or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         acc_q     <= '0;
         win_q     <= '0;
         ovf_int_q <= 1'b0;
         pend_q    <= 1'b0;
         count_q   <= '0;
         fid_q     <= '0;
         ovf_q     <= 1'b0;
         dv_q      <= 1'b0;
         ev_meta_q <= 1'b0;
         ev_sync_q <= 1'b0;
         ev_prev_q <= 1'b0;
`ifdef COLLECT_DEADTIME_EN
         dead_q    <= '0;
`endif
      end else begin
         state_q   <= state_d;
         acc_q     <= acc_d;
         win_q     <= win_d;
         ovf_int_q <= ovf_int_d;
         pend_q    <= pend_d;
         count_q   <= count_d;
         fid_q     <= fid_d;
         ovf_q     <= ovf_d;
         dv_q      <= dv_d;
         ev_meta_q <= event_in;
         ev_sync_q <= ev_meta_q;
         ev_prev_q <= ev_sync_q;
`ifdef COLLECT_DEADTIME_EN
         dead_q    <= dead_d;
`endif
      end
   end

   assign count_data = count_q;
   assign frame_id   = fid_q;
   assign overflow   = ovf_q;
   assign data_valid = dv_q;
   assign state_o    = state_q;

endmodule

// File: tb/tb_collect_window_counter.sv
// tb/tb_collect_window_counter.sv - randomized scoreboard bench for collect_window_counter
module tb_collect_window_counter;

   localparam int CNT_W   = 4;
   localparam int WIN_W   = 8;
   localparam int MAX_WIN = 100;
   localparam int DEAD    = 8;
   localparam int MAXC    = (1 << CNT_W) - 1;

   logic             clk50 = 1'b0;
   logic             rst_n = 1'b0;
   logic             frame_start = 1'b0;
   logic             collect_enable = 1'b0;
   logic             event_in = 1'b0;
   logic             rd_ack = 1'b0;
   logic [CNT_W-1:0] count_data;
   logic [7:0]       frame_id;
   logic             overflow;
   logic             data_valid;
   logic [1:0]       state_o;

   collect_window_counter #(
      .CNT_W(CNT_W), .WIN_W(WIN_W), .MAX_WIN(MAX_WIN), .DEAD_CYCLES(DEAD)
   ) dut (
      .clk50(clk50), .rst_n(rst_n), .frame_start(frame_start),
      .collect_enable(collect_enable), .event_in(event_in), .rd_ack(rd_ack),
      .count_data(count_data), .frame_id(frame_id), .overflow(overflow),
      .data_valid(data_valid), .state_o(state_o)
   );

   always #10 clk50 = ~clk50;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: frame-level rules evaluated once per clock edge.
   int   m_state;          // 0 idle, 1 armed, 2 collect, 3 hold
   int   m_cnt, m_cycles, m_dead;
   bit   m_ovf, m_pend, m_dv;
   int   m_id;
   bit   ev_hist[3];       // event_in as sampled 1, 2, 3 edges ago
   int   exp_q[$];         // packed {ovf, id, count}

   initial begin
      forever begin
         @(posedge clk50 or negedge rst_n);
         if (!rst_n) begin
            m_state = 0; m_cnt = 0; m_cycles = 0; m_dead = 0;
            m_ovf = 0; m_pend = 0; m_dv = 0; m_id = 0;
            ev_hist = '{0, 0, 0};
            exp_q.delete();
         end else begin
            bit seen;
            seen = ev_hist[1] && !ev_hist[2];
            ev_hist[2] = ev_hist[1];
            ev_hist[1] = ev_hist[0];
            ev_hist[0] = event_in;
            case (m_state)
               0: if (frame_start) m_state = 1;
               1: if (collect_enable) begin
                     m_state = 2; m_cnt = 0; m_cycles = 0; m_ovf = 0; m_dead = 0;
                  end
               2: begin
                  bit take;
                  take = seen;
`ifdef COLLECT_DEADTIME_EN
                  take = seen && (m_dead == 0);
                  if (take) m_dead = DEAD;
                  else if (m_dead > 0) m_dead--;
`endif
                  if (take) begin
                     if (m_cnt == MAXC) m_ovf = 1;
                     else m_cnt++;
                  end
                  m_cycles++;
                  if (!collect_enable || frame_start || m_cycles == MAX_WIN) begin
                     m_id = (m_id + 1) % 256;
                     exp_q.push_back((int'(m_ovf) << 16) | (m_id << 8) | m_cnt);
                     m_dv = 1; m_pend = frame_start; m_state = 3;
                  end
               end
               default: begin
                  if (frame_start) m_pend = 1;
                  if (rd_ack) begin
                     m_dv = 0;
                     m_state = m_pend ? 1 : 0;
                     m_pend = 0;
                  end
               end
            endcase
         end
      end
   end

   // Monitor: per-cycle state/valid check, popped scoreboard entry on each new valid.
   bit dv_prev = 0;
   always @(negedge clk50) begin
      if (!rst_n) dv_prev = 0;
      else begin
         check("state_o", state_o, m_state);
         check("data_valid", data_valid, m_dv);
         if (data_valid && !dv_prev) begin
            if (exp_q.size() == 0) check("unexpected_valid", 1, 0);
            else begin
               int e;
               e = exp_q.pop_front();
               check("count_data", count_data, e & 'hFF);
               check("frame_id", frame_id, (e >> 8) & 'hFF);
               check("overflow", overflow, (e >> 16) & 1);
            end
         end
         dv_prev = data_valid;
      end
   end

   // Detector pulses: at least 2 cycles high and 2 low; fast mode drives saturation.
   bit fast_mode = 0;
   initial begin
      forever begin
         @(negedge clk50);
         event_in = 1'b1;
         repeat ($urandom_range(2, 4)) @(negedge clk50);
         event_in = 1'b0;
         repeat (fast_mode ? $urandom_range(2, 3) : $urandom_range(2, 20)) @(negedge clk50);
      end
   end

   int ce_left = 0;
   task automatic drive_cycle();
      @(negedge clk50);
      frame_start = ($urandom_range(0, 59) == 0);
      rd_ack      = ($urandom_range(0, 7) == 0);
      if (ce_left == 0) begin
         collect_enable = ~collect_enable;
         ce_left = collect_enable ? $urandom_range(1, 160) : $urandom_range(1, 25);
      end else ce_left--;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_count"}, count_data, 0);
      check({tag, "_id"},    frame_id, 0);
      check({tag, "_ovf"},   overflow, 0);
      check({tag, "_dv"},    data_valid, 0);
      check({tag, "_state"}, state_o, 0);
   endtask

   initial begin
      repeat (3) @(negedge clk50);
      check_reset_outputs("reset");
      rst_n = 1'b1;
      for (int blk = 0; blk < 8; blk++) begin
         fast_mode = blk[0];
         repeat (5000) drive_cycle();
         if (blk == 3 || blk == 6) begin
            int guard = 0;
            while (m_state != 2 && guard < 3000) begin
               drive_cycle();
               guard++;
            end
            if (guard >= 3000) check("wait_collect_timeout", guard, 0);
            repeat ($urandom_range(1, 20)) drive_cycle();
            #3 rst_n = 1'b0;
            @(negedge clk50);
            check_reset_outputs("midreset");
            @(negedge clk50);
            rst_n = 1'b1;
         end
      end
      check("frames_seen_nonzero", (m_id != 0), 1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
